// File: rtl/io_mmio_responder_pkg.sv
// Shared IO-region offset map and the decode helper used by the MMIO responder.
package io_mmio_responder_pkg;

    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

    typedef enum logic [2:0] {
        SEL_STATUS,
        SEL_RX,
        SEL_TX,
        SEL_CYCLE,
        SEL_INST,
        SEL_CNT_RST,
        SEL_NONE
    } io_sel_e;

    // Word-aligned offset in, register select out; anything unmapped is SEL_NONE.
    function automatic io_sel_e decode_offset(input logic [31:0] word_off);
        io_sel_e sel;
        sel = SEL_NONE;
        case (word_off)
            32'(IO_UART_CTRL): sel = SEL_STATUS;
            32'(IO_UART_RX):   sel = SEL_RX;
            32'(IO_UART_TX):   sel = SEL_TX;
            32'(IO_CYCLE_CNT): sel = SEL_CYCLE;
            32'(IO_INST_CNT):  sel = SEL_INST;
            32'(IO_CNT_RST):   sel = SEL_CNT_RST;
            default:           sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_mmio_responder_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; the head entry is held in a register.
module io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       head_reg, head_next;
    logic             do_push, do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = head_reg;

    // Full/empty are pre-edge flags: a push into a full FIFO is dropped even if a pop frees a slot.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        // Bypass the byte being written when it becomes the new head.
        head_next = mem[rd_ptr_next];
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/io_mmio_responder.sv
// MMIO responder: decodes IO offsets, serves UART status/RX/TX and the cycle/instruction counters.
module io_mmio_responder
    import io_mmio_responder_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 8,
    parameter int OFFSET_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                io_en,
    input  logic                io_we,
    input  logic [OFFSET_W-1:0] io_addr,
    input  logic [31:0]         io_din,
    output logic [31:0]         io_dout,
    input  logic                inst_retired,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);
    logic [OFFSET_W-1:0] word_off;
    io_sel_e             sel;
    logic                is_load, is_store;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic                cnt_clear;
    logic [31:0]         load_data;
    logic [31:0]         io_dout_reg;
    logic [31:0]         cycle_cnt_reg;
    logic [31:0]         inst_cnt_reg;

    assign word_off  = {io_addr[OFFSET_W-1:2], 2'b00};
    assign sel       = decode_offset(32'(word_off));
    assign is_load   = io_en & ~io_we;
    assign is_store  = io_en & io_we;

    assign rx_ready  = rst_n & is_load & (sel == SEL_RX) & rx_valid;
    assign tx_push   = is_store & (sel == SEL_TX);
    assign tx_pop    = tx_valid & tx_ready;
    assign cnt_clear = is_store & (sel == SEL_CNT_RST);
    assign tx_valid  = ~tx_empty;

    io_tx_fifo #(
        .DEPTH(TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (io_din[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_data)
    );

    // Load data is sampled from pre-edge state: counters before this cycle's increment.
    always_comb begin
        load_data = '0;
        case (sel)
            SEL_STATUS: load_data = {30'b0, rx_valid, ~tx_full};
            SEL_RX:     load_data = rx_valid ? {24'b0, rx_data} : 32'b0;
            SEL_CYCLE:  load_data = cycle_cnt_reg;
            SEL_INST:   load_data = inst_cnt_reg;
            default:    load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_dout_reg   <= '0;
            cycle_cnt_reg <= '0;
            inst_cnt_reg  <= '0;
        end else begin
            if (is_load) begin
                io_dout_reg <= load_data;
            end
            if (cnt_clear) begin
                cycle_cnt_reg <= '0;
                inst_cnt_reg  <= '0;
            end else begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                inst_cnt_reg  <= inst_cnt_reg + 32'(inst_retired);
            end
        end
    end

    assign io_dout = io_dout_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, io_din[31:8], io_addr[1:0]};

endmodule
